// File: rtl/mem_responder_pkg.sv
// Shared definitions for the cache-side memory responder: FSM encoding and
// default timing/line-size values.
package mem_responder_pkg;

    localparam int DEF_WAIT_CYCLES = 3;
    localparam int DEF_LINE_BYTES  = 4;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_WACK  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Byte-wide backing store: one synchronous write port and one combinational
// read port so burst beats can follow the beat counter with no extra latency.
module mem_array #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [MEM_AW-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a cache: single-byte writes and aligned line-read
// bursts, each preceded by a fixed number of wait states.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int LINE_BYTES  = DEF_LINE_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        rvalid,
    output logic [7:0]  rdata,
    output logic        rlast,
    output logic        wack
);

    localparam int BEAT_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(LINE_BYTES - 1);
    localparam logic [MEM_AW-1:0]     LINE_MASK = ~(MEM_AW'(LINE_BYTES - 1));
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                  state_reg, state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [BEAT_W-1:0]       beat_reg, beat_next;
    logic                    we_reg;
    logic [MEM_AW-1:0]       addr_reg;
    logic [7:0]              wdata_reg;
    logic                    capture;
    logic                    mem_we;
    logic [MEM_AW-1:0]       mem_raddr;
    logic [7:0]              mem_rdata;

    // Address bits above the store width alias onto the same bytes.
    generate
        if (MEM_AW < 16) begin : g_alias
            logic unused_high_addr;
            assign unused_high_addr = ^addr[15:MEM_AW];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_next     = beat_reg;
        capture       = 1'b0;
        mem_we        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    capture       = 1'b1;
                    wait_cnt_next = WAIT_LOAD;
                    beat_next     = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    mem_we     = we_reg;
                    state_next = we_reg ? ST_WACK : ST_BURST;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_CNT_W'(1);
                end
            end
            ST_BURST: begin
                if (beat_reg == BEAT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    beat_next = beat_reg + BEAT_W'(1);
                end
            end
            ST_WACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Reads keep the line-aligned base so beats index base|beat without carries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            beat_reg     <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_reg     <= beat_next;
            if (capture) begin
                we_reg    <= we;
                wdata_reg <= wdata;
                addr_reg  <= we ? addr[MEM_AW-1:0] : (addr[MEM_AW-1:0] & LINE_MASK);
            end
        end
    end

    assign mem_raddr = addr_reg | MEM_AW'(beat_reg);

    mem_array #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_reg),
        .wdata (wdata_reg),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Outputs decode straight from state so an async reset clears them at once.
    assign busy   = (state_reg != ST_IDLE);
    assign rvalid = (state_reg == ST_BURST);
    assign rlast  = (state_reg == ST_BURST) && (beat_reg == BEAT_LAST);
    assign wack   = (state_reg == ST_WACK);
    assign rdata  = (state_reg == ST_BURST) ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (3 and 0 wait states) share stimulus and
// are compared every cycle against a transaction-level model.
module tb_mem_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;

    logic       busy0, rvalid0, rlast0, wack0;
    logic [7:0] rdata0;
    logic       busy1, rvalid1, rlast1, wack1;
    logic [7:0] rdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.MEM_AW(10), .WAIT_CYCLES(3), .LINE_BYTES(L)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy0), .rvalid(rvalid0), .rdata(rdata0), .rlast(rlast0), .wack(wack0)
    );

    mem_responder #(.MEM_AW(10), .WAIT_CYCLES(0), .LINE_BYTES(L)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy1), .rvalid(rvalid1), .rdata(rdata1), .rlast(rlast1), .wack(wack1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access per instance, tracked by
    // the number of edges since it was accepted.
    int  mw [2] = '{3, 0};
    bit  m_act [2];
    bit  m_we [2];
    int  m_k [2];
    int  m_addr [2];
    int  m_wd [2];
    int  m_mem [2][1024];

    initial begin
        bit s_req, s_we, s_rst;
        int s_addr, s_wd;
        forever begin
            @(posedge clk);
            s_req = req; s_we = we; s_rst = rst;
            s_addr = int'(addr); s_wd = int'(wdata);
            for (int j = 0; j < 2; j++) begin
                if (s_rst) begin
                    m_act[j] = 1'b0;
                end else if (m_act[j]) begin
                    m_k[j]++;
                    if (m_we[j] && m_k[j] == mw[j] + 1)
                        m_mem[j][m_addr[j]] = m_wd[j];
                    if (m_k[j] == (m_we[j] ? mw[j] + 2 : mw[j] + 1 + L))
                        m_act[j] = 1'b0;
                end else if (s_req) begin
                    m_act[j]  = 1'b1;
                    m_k[j]    = 0;
                    m_we[j]   = s_we;
                    m_addr[j] = s_we ? (s_addr % 1024) : ((s_addr % 1024) / L) * L;
                    m_wd[j]   = s_wd;
                end
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                int beat, e_rv, e_rd, e_rl, e_wk;
                beat = m_k[j] - (mw[j] + 1);
                e_rv = (m_act[j] && !m_we[j] && beat >= 0 && beat < L) ? 1 : 0;
                e_rd = e_rv ? m_mem[j][m_addr[j] + beat] : 0;
                e_rl = (e_rv && beat == L - 1) ? 1 : 0;
                e_wk = (m_act[j] && m_we[j] && m_k[j] == mw[j] + 1) ? 1 : 0;
                check($sformatf("busy[%0d]", j),   j == 0 ? int'(busy0)   : int'(busy1),   int'(m_act[j]));
                check($sformatf("rvalid[%0d]", j), j == 0 ? int'(rvalid0) : int'(rvalid1), e_rv);
                check($sformatf("rdata[%0d]", j),  j == 0 ? int'(rdata0)  : int'(rdata1),  e_rd);
                check($sformatf("rlast[%0d]", j),  j == 0 ? int'(rlast0)  : int'(rlast1),  e_rl);
                check($sformatf("wack[%0d]", j),   j == 0 ? int'(wack0)   : int'(wack1),   e_wk);
            end
        end
    end

    // Per-request observations: index k holds outputs just after edge T0+k.
    int o_busy0 [12];
    int o_rv0 [12];
    int o_rd0 [12];
    int o_rl0 [12];
    int o_wk0 [12];
    int o_rv1 [12];
    int o_rd1 [12];
    int o_rl1 [12];

    function automatic void record(input int k);
        o_busy0[k] = int'(busy0); o_rv0[k] = int'(rvalid0); o_rd0[k] = int'(rdata0);
        o_rl0[k] = int'(rlast0);  o_wk0[k] = int'(wack0);
        o_rv1[k] = int'(rvalid1); o_rd1[k] = int'(rdata1); o_rl1[k] = int'(rlast1);
    endfunction

    task automatic run_req(input bit w, input logic [15:0] a, input logic [7:0] d,
                           input int hold, input int rst_at);
        int t = 0;
        @(negedge clk);
        while ((busy0 || busy1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_timeout", int'(busy0 || busy1), 0);
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            record(k);
            if (k >= hold) req = 1'b0;
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("rst_busy0", int'(busy0), 0);
                check("rst_rvalid0", int'(rvalid0), 0);
                check("rst_rlast0", int'(rlast0), 0);
                check("rst_rdata0", int'(rdata0), 0);
                check("rst_busy1", int'(busy1), 0);
                req = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                $display("txn reset at beat index %0d", k);
                return;
            end
        end
        req = 1'b0;
        $display("txn %s addr=0x%04h wdata=0x%02h hold=%0d", w ? "WR" : "RD", a, d, hold);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy0", int'(busy0), 0);
        check("reset_rdata0", int'(rdata0), 0);
        check("reset_rvalid0", int'(rvalid0), 0);
        check("reset_wack1", int'(wack1), 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 64; i++) run_req(1'b1, 16'(i), 8'($urandom), 0, -1);

        // single write timing
        run_req(1'b1, 16'h0012, 8'hA5, 0, -1);
        check("wr_wack_T0+4", o_wk0[3], 0);
        check("wr_wack_T0+5", o_wk0[4], 1);
        check("wr_wack_T0+6", o_wk0[5], 0);
        check("wr_busy_T0+5", o_busy0[4], 1);
        check("wr_busy_T0+6", o_busy0[5], 0);

        // line read from an unaligned address
        run_req(1'b1, 16'h0010, 8'h11, 0, -1);
        run_req(1'b1, 16'h0011, 8'h22, 0, -1);
        run_req(1'b1, 16'h0012, 8'h33, 0, -1);
        run_req(1'b1, 16'h0013, 8'h44, 0, -1);
        run_req(1'b0, 16'h0013, 8'h00, 0, -1);
        check("rd_rvalid_pre", o_rv0[3], 0);
        check("rd_beat0", o_rd0[4], 'h11);
        check("rd_beat1", o_rd0[5], 'h22);
        check("rd_beat2", o_rd0[6], 'h33);
        check("rd_beat3", o_rd0[7], 'h44);
        check("rd_rlast_b2", o_rl0[6], 0);
        check("rd_rlast_b3", o_rl0[7], 1);
        check("rd_rvalid_post", o_rv0[8], 0);
        check("w0_rvalid_T0+1", o_rv1[0], 0);
        check("w0_rvalid_T0+2", o_rv1[1], 1);
        check("w0_beat0", o_rd1[1], 'h11);
        check("w0_beat3", o_rd1[4], 'h44);
        check("w0_rlast", o_rl1[4], 1);
        check("w0_rvalid_end", o_rv1[5], 0);

        // requests held during a burst are ignored until busy falls
        run_req(1'b0, 16'h0010, 8'h00, 11, -1);
        check("hold_beat1", o_rd0[5], 'h22);
        check("hold_busy_drop", o_busy0[8], 0);
        check("hold_reaccept", o_busy0[9], 1);

        // reset during beat 2, then a clean read
        run_req(1'b0, 16'h0010, 8'h00, 0, 6);
        check("rst_pre_beat2", o_rd0[6], 'h33);
        run_req(1'b0, 16'h0011, 8'h00, 0, -1);
        check("post_rst_beat0", o_rd0[4], 'h11);
        check("post_rst_beat3", o_rd0[7], 'h44);

        // aliasing and read-after-write
        run_req(1'b1, 16'h0400, 8'h5C, 0, -1);
        run_req(1'b0, 16'h0000, 8'h00, 0, -1);
        check("alias_beat0", o_rd0[4], 'h5C);
        check("alias_beat0_w0", o_rd1[1], 'h5C);

        // randomized traffic confined to the preloaded 64-byte window
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = 16'(($urandom & 32'hFC00) | $urandom_range(0, 63));
            wdata = 8'($urandom);
            if (req) $display("txn rand req we=%0d addr=0x%04h wdata=0x%02h", we, addr, wdata);
        end
        @(negedge clk) req = 1'b0;
        t = 0;
        while ((busy0 || busy1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("final_idle_timeout", int'(busy0 || busy1), 0);
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_AW, default 10, backing-store address width in bits (2^MEM_AW bytes).
REQ-002 Parameter WAIT_CYCLES, default 3, wait states inserted before each access completes (0..15).
REQ-003 Parameter LINE_BYTES, default 4, read burst length in bytes (power of two, 1..8).
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  1  request strobe from cache; sampled only while busy=0.
REQ-008 we  input  1  1 = single-byte write, 0 = line read; qualified by req.
REQ-009 addr  input  16  byte address; qualified by req.
REQ-010 wdata  input  8  write data; qualified by req with we=1.
REQ-011 busy  output  1  high while a request is in progress.
REQ-012 rvalid  output  1  read beat valid.
REQ-013 rdata  output  8  read beat data; meaningful only when rvalid=1.
REQ-014 rlast  output  1  high with the final read beat.
REQ-015 wack  output  1  one-cycle write-complete pulse.

Function
REQ-016 FSM states IDLE, WAIT, BURST, WACK; one-hot or binary encoding is free.
REQ-017 IDLE: edge T0 with req=1 captures we, wdata and addr, loads wait counter with WAIT_CYCLES, enters WAIT; busy=1 from T0.
REQ-018 Read base address = addr with low log2(LINE_BYTES) bits cleared; address bits at and above MEM_AW are ignored (aliasing).
REQ-019 WAIT: counter decrements each edge; at the edge where counter==0, go to BURST (read) or WACK (write); WAIT_CYCLES=0 gives one WAIT cycle.
REQ-020 Read latency: first beat valid in the cycle after edge T0+WAIT_CYCLES+1; beats on LINE_BYTES consecutive cycles, no gaps.
REQ-021 Beat i (0..LINE_BYTES-1) drives rdata = mem[base+i]; rlast=1 only on beat LINE_BYTES-1; after that beat's edge, state=IDLE, busy=0.
REQ-022 Write: on the WAIT->WACK edge mem[addr] <= captured wdata; wack=1 for exactly the WACK cycle; next edge to IDLE, busy=0.
REQ-023 req while busy=1 is ignored, not queued; a new request may be accepted on the first edge with busy=0.
REQ-024 Read of a byte written by the immediately preceding write returns the new value.
REQ-025 rvalid, rlast, wack are never high outside BURST/WACK; rdata holds 8'h00 outside BURST.
REQ-026 Memory contents are not initialised; a bench preloads via writes or hierarchical init.

Reset
REQ-027 rst=1 forces state IDLE, counter 0, busy=0, rvalid=0, rlast=0, wack=0, rdata=8'h00, immediately and asynchronously.
REQ-028 rst mid-burst or mid-wait aborts the access with no further beats; a write aborted before WACK does not modify memory.
REQ-029 First request may be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package holds the state encoding constants and the default LINE_BYTES/WAIT_CYCLES values.
REQ-031 Storage is one sub-module mem_array (synchronous write port, combinational read port, MEM_AW/8-bit parameters); FSM, counters and capture registers live in mem_responder.

Verification
REQ-032 Write 8'hA5 to 16'h0012 (WAIT_CYCLES=3) -> wack high exactly in cycle T0+5 (one pulse), busy low the cycle after.
REQ-033 Preload 16'h0010..13 with 11,22,33,44; read addr 16'h0013 -> beats 11,22,33,44 in cycles T0+5..T0+8, rlast on 44 only.
REQ-034 WAIT_CYCLES=0 read of 16'h0010 -> first rvalid at T0+2, four contiguous beats.
REQ-035 req pulsed every cycle during a read burst -> only the first request served; next accepted after busy falls.
REQ-036 Assert rst during beat 2 of a burst -> rvalid/rlast/busy drop immediately, no further beats; subsequent read returns correct data.
REQ-037 Write 8'h5C to 16'h0400 (MEM_AW=10), read 16'h0000 line -> beat 0 = 8'h5C (aliasing).
